// File: rtl/axis_endian_bridge_pkg.sv
// axis_endian_bridge_pkg: shared constants, skid-buffer occupancy states and the
// group byte-swap helper used by the endian bridge.
package axis_endian_bridge_pkg;

  // Parameter legality limits for the bridge
  localparam int unsigned DATA_WIDTH_ALIGN = 16;
  localparam int unsigned MIN_SWAP_BYTES   = 2;
  localparam int unsigned MAX_DATA_WIDTH   = 2048;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  // True when the data width / swap-group combination is supported
  function automatic bit swap_params_legal(input int unsigned data_width,
                                           input int unsigned swap_bytes);
    bit legal;
    legal = 1'b1;
    if (data_width == 0) legal = 1'b0;
    if (data_width > MAX_DATA_WIDTH) legal = 1'b0;
    if ((data_width % DATA_WIDTH_ALIGN) != 0) legal = 1'b0;
    if (swap_bytes < MIN_SWAP_BYTES) legal = 1'b0;
    if (!is_pow2(swap_bytes)) legal = 1'b0;
    if ((swap_bytes != 0) && (((data_width / 8) % swap_bytes) != 0)) legal = 1'b0;
    return legal;
  endfunction

  // Reverse the order of lanes inside every group of 'group' lanes.
  // lane_bits is 8 for tdata (byte lanes) and 1 for tstrb (one bit per byte).
  function automatic logic [MAX_DATA_WIDTH-1:0] swap_lanes(
    input logic [MAX_DATA_WIDTH-1:0] din,
    input int unsigned               lane_bits,
    input int unsigned               lanes,
    input int unsigned               group
  );
    logic [MAX_DATA_WIDTH-1:0] dout;
    int unsigned lane;
    int unsigned offset;
    int unsigned src_lane;
    dout = '0;
    for (int unsigned b = 0; b < lanes * lane_bits; b++) begin
      lane     = b / lane_bits;
      offset   = b % lane_bits;
      src_lane = (lane / group) * group + (group - 1 - (lane % group));
      dout[b]  = din[src_lane * lane_bits + offset];
    end
    return dout;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry skid buffer with registered valid/ready/data.
// Entry one is the output register, entry two the skid register that catches
// the beat accepted in the cycle the downstream stalls.
module axis_skid_buffer
  import axis_endian_bridge_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  occ_e             occ_q;
  occ_e             occ_d;
  logic [WIDTH-1:0] m_data_q;
  logic [WIDTH-1:0] m_data_d;
  logic [WIDTH-1:0] skid_data_q;
  logic [WIDTH-1:0] skid_data_d;
  logic             m_valid_q;
  logic             m_valid_d;
  logic             s_ready_q;
  logic             s_ready_d;
  logic             push;
  logic             pop;

  assign push = s_valid && s_ready_q;
  assign pop  = m_valid_q && m_ready;

  // Next occupancy and entry contents from the push/pop handshakes
  always_comb begin
    occ_d       = occ_q;
    m_data_d    = m_data_q;
    skid_data_d = skid_data_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          m_data_d = s_data;
          occ_d    = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          m_data_d = s_data;
        end else if (push) begin
          skid_data_d = s_data;
          occ_d       = OCC_FULL;
        end else if (pop) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          m_data_d = skid_data_q;
          occ_d    = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase
    m_valid_d = (occ_d != OCC_EMPTY);
    s_ready_d = (occ_d != OCC_FULL);
  end

  // State and output registers; ready stays low through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q       <= OCC_EMPTY;
      m_data_q    <= '0;
      skid_data_q <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      m_data_q    <= m_data_d;
      skid_data_q <= skid_data_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;

endmodule

// File: rtl/axis_endian_bridge.sv
// axis_endian_bridge: AXI-Stream bridge that optionally reverses byte order
// inside C_SWAP_BYTES groups of tdata/tstrb. The swap decision is taken on the
// first beat of each packet and held until that packet's tlast.
// Optional build macro ENDIAN_BRIDGE_STATS_EN adds pkt_count/swapped_pkt_count.
module axis_endian_bridge
  import axis_endian_bridge_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_SWAP_BYTES       = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            swap_mode,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready
`ifdef ENDIAN_BRIDGE_STATS_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     swapped_pkt_count
`endif
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int PW = DW + SW + UW + 1;

  if (!swap_params_legal(C_AXIS_DATA_WIDTH, C_SWAP_BYTES)) begin : g_bad_params
    $error("axis_endian_bridge: unsupported C_AXIS_DATA_WIDTH / C_SWAP_BYTES combination");
  end

  logic          s_beat;
  logic          sop_q;
  logic          sop_d;
  logic          mode_q;
  logic          mode_d;
  logic          beat_mode;
  logic [DW-1:0] tdata_swapped;
  logic [SW-1:0] tstrb_swapped;
  logic [DW-1:0] tdata_in;
  logic [SW-1:0] tstrb_in;
  logic [PW-1:0] s_payload;
  logic [PW-1:0] m_payload;

  assign s_beat    = s_axis_tvalid && s_axis_tready;
  assign beat_mode = sop_q ? swap_mode : mode_q;

  // Track packet boundaries and latch the swap mode on each first beat
  always_comb begin
    sop_d  = sop_q;
    mode_d = mode_q;
    if (s_beat) begin
      mode_d = beat_mode;
      sop_d  = s_axis_tlast;
    end
  end

  // Packet-start flag and latched mode registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop_q  <= 1'b1;
      mode_q <= 1'b0;
    end else begin
      sop_q  <= sop_d;
      mode_q <= mode_d;
    end
  end

  assign tdata_swapped = DW'(swap_lanes(MAX_DATA_WIDTH'(s_axis_tdata), 8, SW, C_SWAP_BYTES));
  assign tstrb_swapped = SW'(swap_lanes(MAX_DATA_WIDTH'(s_axis_tstrb), 1, SW, C_SWAP_BYTES));
  assign tdata_in      = beat_mode ? tdata_swapped : s_axis_tdata;
  assign tstrb_in      = beat_mode ? tstrb_swapped : s_axis_tstrb;
  assign s_payload     = {s_axis_tlast, s_axis_tuser, tstrb_in, tdata_in};

  axis_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_payload),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_payload),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = m_payload[DW-1:0];
  assign m_axis_tstrb = m_payload[DW+SW-1:DW];
  assign m_axis_tuser = m_payload[DW+SW+UW-1:DW+SW];
  assign m_axis_tlast = m_payload[PW-1];

`ifdef ENDIAN_BRIDGE_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] pkt_count_d;
  logic [31:0] swapped_pkt_count_q;
  logic [31:0] swapped_pkt_count_d;

  // Count packets when their tlast beat is accepted; counters wrap naturally
  always_comb begin
    pkt_count_d         = pkt_count_q;
    swapped_pkt_count_d = swapped_pkt_count_q;
    if (s_beat && s_axis_tlast) begin
      pkt_count_d = pkt_count_q + 32'd1;
      if (beat_mode) begin
        swapped_pkt_count_d = swapped_pkt_count_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_q         <= '0;
      swapped_pkt_count_q <= '0;
    end else begin
      pkt_count_q         <= pkt_count_d;
      swapped_pkt_count_q <= swapped_pkt_count_d;
    end
  end

  assign pkt_count         = pkt_count_q;
  assign swapped_pkt_count = swapped_pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_endian_bridge.sv
// tb_axis_endian_bridge: directed, self-checking bench for axis_endian_bridge.
// Two instances (8-byte and 4-byte swap groups, 64-bit data, 8-bit tuser) share
// one input stream so each vector checks both group sizes.
`timescale 1ns/1ps
module tb_axis_endian_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        swap_mode;
  logic [63:0] s_tdata;
  logic [7:0]  s_tstrb;
  logic [7:0]  s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        m_tready;

  logic        s_ready8, s_ready4;
  logic [63:0] m_data8, m_data4;
  logic [7:0]  m_strb8, m_strb4;
  logic [7:0]  m_user8, m_user4;
  logic        m_last8, m_last4;
  logic        m_valid8, m_valid4;

`ifdef ENDIAN_BRIDGE_STATS_EN
  logic [31:0] pkt8, swp8, pkt4, swp4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mode;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic [63:0] exp8_data;
    logic [7:0]  exp8_strb;
    logic [63:0] exp4_data;
    logic [7:0]  exp4_strb;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  vec_t        vecs[6];
  beat_t       q8[$];
  beat_t       q4[$];
  logic [63:0] seq8[5];
  logic [63:0] seq4[5];
  int          idx;
  bit          will_accept;

  always #5 clk = ~clk;

  axis_endian_bridge #(
    .C_AXIS_DATA_WIDTH  (64),
    .C_AXIS_TUSER_WIDTH (8),
    .C_SWAP_BYTES       (8)
  ) dut_g8 (
    .clk           (clk),
    .reset         (reset),
    .swap_mode     (swap_mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_ready8),
    .m_axis_tdata  (m_data8),
    .m_axis_tstrb  (m_strb8),
    .m_axis_tuser  (m_user8),
    .m_axis_tlast  (m_last8),
    .m_axis_tvalid (m_valid8),
    .m_axis_tready (m_tready)
`ifdef ENDIAN_BRIDGE_STATS_EN
    ,
    .pkt_count         (pkt8),
    .swapped_pkt_count (swp8)
`endif
  );

  axis_endian_bridge #(
    .C_AXIS_DATA_WIDTH  (64),
    .C_AXIS_TUSER_WIDTH (8),
    .C_SWAP_BYTES       (4)
  ) dut_g4 (
    .clk           (clk),
    .reset         (reset),
    .swap_mode     (swap_mode),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_ready4),
    .m_axis_tdata  (m_data4),
    .m_axis_tstrb  (m_strb4),
    .m_axis_tuser  (m_user4),
    .m_axis_tlast  (m_last4),
    .m_axis_tvalid (m_valid4),
    .m_axis_tready (m_tready)
`ifdef ENDIAN_BRIDGE_STATS_EN
    ,
    .pkt_count         (pkt4),
    .swapped_pkt_count (swp4)
`endif
  );

  // Record every beat leaving each instance, sampled mid-cycle before its handshake edge
  always @(negedge clk) begin
    if (!reset && m_tready) begin
      if (m_valid8) q8.push_back(beat_t'{m_data8, m_strb8, m_user8, m_last8});
      if (m_valid4) q4.push_back(beat_t'{m_data4, m_strb4, m_user4, m_last4});
    end
  end

  // Hard stop in case a sequence never returns
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one beat and hold it until the bridge accepts it (bounded)
  task automatic applyStimulus(input logic mode, input logic [63:0] data,
                               input logic [7:0] strb, input logic [7:0] user,
                               input logic last);
    bit accepted;
    accepted  = 1'b0;
    swap_mode = mode;
    s_tdata   = data;
    s_tstrb   = strb;
    s_tuser   = user;
    s_tlast   = last;
    s_tvalid  = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = s_ready8;
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got s_ready 0 expected 1");
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h0011223344556677, 8'h0F, 8'h01,
                64'h7766554433221100, 8'hF0, 64'h3322110077665544, 8'h0F};
    vecs[1] = '{1'b1, 64'h0123456789ABCDEF, 8'h01, 8'h02,
                64'hEFCDAB8967452301, 8'h80, 64'h67452301EFCDAB89, 8'h08};
    vecs[2] = '{1'b0, 64'h0011223344556677, 8'h0F, 8'h03,
                64'h0011223344556677, 8'h0F, 64'h0011223344556677, 8'h0F};
    vecs[3] = '{1'b1, 64'hFF00000000000000, 8'h81, 8'h04,
                64'h00000000000000FF, 8'h81, 64'h000000FF00000000, 8'h18};
    vecs[4] = '{1'b1, 64'h00000000DEADBEEF, 8'h3C, 8'h05,
                64'hEFBEADDE00000000, 8'h3C, 64'h00000000EFBEADDE, 8'hC3};
    vecs[5] = '{1'b0, 64'h0123456789ABCDEF, 8'hA5, 8'h06,
                64'h0123456789ABCDEF, 8'hA5, 64'h0123456789ABCDEF, 8'hA5};

    seq8[0] = 64'h7766554433221100;  seq4[0] = 64'h3322110077665544;
    seq8[1] = 64'hEFCDAB8967452301;  seq4[1] = 64'h67452301EFCDAB89;
    seq8[2] = 64'hEFBEADDE00000000;  seq4[2] = 64'h00000000EFBEADDE;
    seq8[3] = 64'h00000000000000FF;  seq4[3] = 64'h000000FF00000000;
    seq8[4] = 64'h0011223344556677;  seq4[4] = 64'h0011223344556677;

    reset     = 1'b1;
    swap_mode = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_tuser   = '0;
    s_tlast   = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset m_valid8", 64'(m_valid8), 64'd0);
    checkOutput("reset m_valid4", 64'(m_valid4), 64'd0);
    checkOutput("reset s_ready8", 64'(s_ready8), 64'd0);
    checkOutput("reset s_ready4", 64'(s_ready4), 64'd0);
    checkOutput("reset m_data8", m_data8, 64'd0);
    checkOutput("reset m_strb8", 64'(m_strb8), 64'd0);
    checkOutput("reset m_user8", 64'(m_user8), 64'd0);
    checkOutput("reset m_last8", 64'(m_last8), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("s_ready before first edge", 64'(s_ready8), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("s_ready after first edge", 64'(s_ready8), 64'd1);

    // Single-beat packets, each output expected one cycle after acceptance
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].data, vecs[i].strb, vecs[i].user, 1'b1);
      s_tvalid = 1'b0;
      checkOutput($sformatf("vec%0d valid8", i), 64'(m_valid8), 64'd1);
      checkOutput($sformatf("vec%0d data8", i), m_data8, vecs[i].exp8_data);
      checkOutput($sformatf("vec%0d strb8", i), 64'(m_strb8), 64'(vecs[i].exp8_strb));
      checkOutput($sformatf("vec%0d user8", i), 64'(m_user8), 64'(vecs[i].user));
      checkOutput($sformatf("vec%0d last8", i), 64'(m_last8), 64'd1);
      checkOutput($sformatf("vec%0d data4", i), m_data4, vecs[i].exp4_data);
      checkOutput($sformatf("vec%0d strb4", i), 64'(m_strb4), 64'(vecs[i].exp4_strb));
    end
    waitCycles(2);
    checkOutput("drained m_valid8", 64'(m_valid8), 64'd0);
    checkOutput("empty holds data8", m_data8, vecs[5].exp8_data);

    // Mode changes mid-packet are ignored; the next packet samples afresh
    q8.delete();
    q4.delete();
    applyStimulus(1'b1, 64'h0011223344556677, 8'hFF, 8'h20, 1'b0);
    applyStimulus(1'b0, 64'h0123456789ABCDEF, 8'hFF, 8'h21, 1'b0);
    applyStimulus(1'b0, 64'h00000000DEADBEEF, 8'hFF, 8'h22, 1'b0);
    applyStimulus(1'b0, 64'hFF00000000000000, 8'hFF, 8'h23, 1'b1);
    applyStimulus(1'b0, 64'h0011223344556677, 8'hFF, 8'h24, 1'b1);
    s_tvalid = 1'b0;
    waitCycles(3);
    checkOutput("mode seq beats8", 64'(q8.size()), 64'd5);
    checkOutput("mode seq beats4", 64'(q4.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q8.size()) begin
        checkOutput($sformatf("mode seq%0d data8", i), q8[i].data, seq8[i]);
        checkOutput($sformatf("mode seq%0d user8", i), 64'(q8[i].user), 64'(8'h20 + 8'(i)));
        checkOutput($sformatf("mode seq%0d last8", i), 64'(q8[i].last), 64'(i >= 3));
      end
      if (i < q4.size()) begin
        checkOutput($sformatf("mode seq%0d data4", i), q4[i].data, seq4[i]);
      end
    end

    // Downstream stall for 5 cycles under continuous input
    q8.delete();
    q4.delete();
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
      if (cyc == 5) begin
        checkOutput("stall beats accepted", 64'(idx), 64'd2);
        checkOutput("stall s_ready8", 64'(s_ready8), 64'd0);
        checkOutput("stall m_valid8", 64'(m_valid8), 64'd1);
        checkOutput("stall m_data8", m_data8, 64'h1000);
        checkOutput("stall nothing delivered", 64'(q8.size()), 64'd0);
      end
      m_tready  = (cyc >= 5);
      swap_mode = 1'b0;
      s_tdata   = 64'h1000 + 64'(idx);
      s_tstrb   = 8'hFF;
      s_tuser   = 8'(idx);
      s_tlast   = (idx == 5);
      s_tvalid  = 1'b1;
      will_accept = s_ready8;
      @(posedge clk);
      #1;
      if (will_accept) idx++;
    end
    s_tvalid = 1'b0;
    checkOutput("stall all beats sent", 64'(idx), 64'd6);
    waitCycles(4);
    checkOutput("stall beats out8", 64'(q8.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < q8.size()) begin
        checkOutput($sformatf("stall order%0d data8", i), q8[i].data, 64'h1000 + 64'(i));
        checkOutput($sformatf("stall order%0d user8", i), 64'(q8[i].user), 64'(i));
      end
    end

    // Reset in the middle of a swapped packet
    m_tready = 1'b0;
    applyStimulus(1'b1, 64'h0011223344556677, 8'hFF, 8'h30, 1'b0);
    applyStimulus(1'b1, 64'h0123456789ABCDEF, 8'hFF, 8'h31, 1'b0);
    s_tvalid = 1'b0;
    checkOutput("pre-reset m_valid8", 64'(m_valid8), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid reset m_valid8", 64'(m_valid8), 64'd0);
    checkOutput("mid reset s_ready8", 64'(s_ready8), 64'd0);
    checkOutput("mid reset m_data8", m_data8, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post reset s_ready8", 64'(s_ready8), 64'd1);
    applyStimulus(1'b0, 64'h0011223344556677, 8'h0F, 8'h32, 1'b1);
    s_tvalid = 1'b0;
    checkOutput("post reset valid8", 64'(m_valid8), 64'd1);
    checkOutput("post reset data8", m_data8, 64'h0011223344556677);
    checkOutput("post reset strb8", 64'(m_strb8), 64'h0F);
    checkOutput("post reset data4", m_data4, 64'h0011223344556677);

`ifdef ENDIAN_BRIDGE_STATS_EN
    // Packet statistics and counter wrap
    doReset();
    @(posedge clk);
    #1;
    checkOutput("stats reset pkt", 64'(pkt8), 64'd0);
    checkOutput("stats reset swapped", 64'(swp8), 64'd0);
    applyStimulus(1'b1, 64'h0011223344556677, 8'hFF, 8'h40, 1'b1);
    applyStimulus(1'b0, 64'h0011223344556677, 8'hFF, 8'h41, 1'b1);
    applyStimulus(1'b1, 64'h0011223344556677, 8'hFF, 8'h42, 1'b1);
    s_tvalid = 1'b0;
    waitCycles(2);
    checkOutput("stats pkt_count", 64'(pkt8), 64'd3);
    checkOutput("stats swapped_pkt_count", 64'(swp8), 64'd2);
    force dut_g8.pkt_count_q = 32'hFFFF_FFFF;
    force dut_g8.swapped_pkt_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut_g8.pkt_count_q;
    release dut_g8.swapped_pkt_count_q;
    applyStimulus(1'b1, 64'h0011223344556677, 8'hFF, 8'h43, 1'b1);
    s_tvalid = 1'b0;
    waitCycles(2);
    checkOutput("stats pkt wrap", 64'(pkt8), 64'd0);
    checkOutput("stats swapped wrap", 64'(swp8), 64'd0);
    checkOutput("stats g4 pkt_count", 64'(pkt4), 64'd4);
    checkOutput("stats g4 swapped", 64'(swp4), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
